// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests a word from instruction memory, holds it for the
// datapath until accepted, then computes the next PC from jump/branch/zero.
module fetch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        halt,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [2:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [15:0] pc
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFetch = 2'd1;
   localparam logic [1:0] StIssue = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] instr_q, instr_d;
   logic [2:0]  opcode_q, opcode_d;
   logic        valid_q, valid_d;

   logic [15:0] pc_plus1;
   logic [15:0] br_target;
   logic [15:0] next_pc;
   logic        accept;

   assign pc_plus1  = pc_q + 16'd1;
   assign br_target = pc_plus1 + {{9{instr_q[6]}}, instr_q[6:0]};
   assign accept    = valid_q & instr_ready;

   // Jump keeps the 8K region of pc+1; it wins over a taken branch.
   always_comb begin
      next_pc = pc_plus1;
      if (jump) begin
         next_pc = {pc_plus1[15:13], instr_q[12:0]};
      end else if (branch && zero) begin
         next_pc = br_target;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_d    = req_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      opcode_d = opcode_q;
      valid_d  = valid_q;
      case (state_q)
         StIdle: begin
            if (!halt) begin
               state_d = StFetch;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
         end
         StFetch: begin
            if (imem_ack) begin
               state_d  = StIssue;
               req_d    = 1'b0;
               instr_d  = imem_rdata;
               opcode_d = imem_rdata[15:13];
               valid_d  = 1'b1;
            end
         end
         StIssue: begin
            if (accept) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               if (halt) begin
                  state_d = StIdle;
               end else begin
                  state_d = StFetch;
                  req_d   = 1'b1;
                  addr_d  = next_pc;
               end
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         pc_q     <= 16'h0000;
         req_q    <= 1'b0;
         addr_q   <= 16'h0000;
         instr_q  <= 16'h0000;
         opcode_q <= 3'b000;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         opcode_q <= opcode_d;
         valid_q  <= valid_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr       = instr_q;
   assign opcode      = opcode_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds each word handed to the
// memory port and is checked against the instruction the unit issues.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        halt;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic [2:0]  opcode;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump;
   logic        branch;
   logic        zero;
   logic [15:0] pc;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } item_t;

   item_t       sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_pc;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .halt        (halt),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jump        (jump),
      .branch      (branch),
      .zero        (zero),
      .pc          (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_next(input logic [15:0] p, input logic [15:0] i,
                                              input logic j, input logic b, input logic z);
      logic [15:0] p1;
      p1 = p + 16'd1;
      if (j) return {p1[15:13], i[12:0]};
      if (b && z) return p1 + {{9{i[6]}}, i[6:0]};
      return p1;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_req"},    16'(imem_req),    16'h0000);
      chk({tag, "_addr"},   imem_addr,        16'h0000);
      chk({tag, "_instr"},  instr,            16'h0000);
      chk({tag, "_opcode"}, 16'(opcode),      16'h0000);
      chk({tag, "_valid"},  16'(instr_valid), 16'h0000);
      chk({tag, "_pc"},     pc,               16'h0000);
   endtask

   // One full transaction: wait states on the memory side, then backpressure on issue.
   task automatic fetch(input logic [15:0] rdata, input int wait_n, input int hold_n,
                        input logic j, input logic b, input logic z, input logic h);
      int    n;
      item_t it;
      halt = h;
      n = 0;
      while (!imem_req && n < 20) begin
         step();
         n++;
      end
      chk("req_seen", 16'(imem_req), 16'h0001);
      if (!imem_req) return;
      chk("fetch_addr", imem_addr, exp_pc);
      chk("fetch_pc", pc, exp_pc);
      for (int i = 0; i < wait_n; i++) begin
         // A stray ready/jump while nothing is valid must not move the PC.
         instr_ready = 1'b1;
         jump        = 1'b1;
         step();
         chk("wait_req", 16'(imem_req), 16'h0001);
         chk("wait_addr", imem_addr, exp_pc);
         chk("wait_pc", pc, exp_pc);
         chk("wait_valid", 16'(instr_valid), 16'h0000);
      end
      instr_ready = 1'b0;
      jump        = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = rdata;
      it.instr    = rdata;
      it.pc       = exp_pc;
      sb.push_back(it);
      step();
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      chk("req_drop", 16'(imem_req), 16'h0000);
      chk("valid_set", 16'(instr_valid), 16'h0001);
      if (sb.size() > 0) begin
         it = sb.pop_front();
         chk("issue_instr", instr, it.instr);
         chk("issue_opcode", 16'(opcode), 16'(it.instr[15:13]));
         chk("issue_pc", pc, it.pc);
      end
      for (int i = 0; i < hold_n; i++) begin
         // Acks outside FETCH carry garbage and must be ignored.
         imem_ack   = 1'b1;
         imem_rdata = ~rdata;
         step();
         chk("hold_valid", 16'(instr_valid), 16'h0001);
         chk("hold_instr", instr, it.instr);
         chk("hold_pc", pc, it.pc);
         chk("hold_req", 16'(imem_req), 16'h0000);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      jump        = j;
      branch      = b;
      zero        = z;
      step();
      instr_ready = 1'b0;
      jump        = 1'b0;
      branch      = 1'b0;
      zero        = 1'b0;
      exp_pc = model_next(exp_pc, rdata, j, b, z);
      chk("accept_valid", 16'(instr_valid), 16'h0000);
      chk("accept_pc", pc, exp_pc);
      if (!h) begin
         chk("next_req", 16'(imem_req), 16'h0001);
         chk("next_addr", imem_addr, exp_pc);
      end else begin
         chk("halt_req", 16'(imem_req), 16'h0000);
      end
   endtask

   initial begin
      reset       = 1'b1;
      halt        = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = 16'hFFFF;
      instr_ready = 1'b1;
      jump        = 1'b0;
      branch      = 1'b0;
      zero        = 1'b0;
      exp_pc      = 16'h0000;
      step();
      step();
      chk_reset("rst");
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
      reset       = 1'b0;
      step();
      chk("first_req", 16'(imem_req), 16'h0001);
      chk("first_addr", imem_addr, 16'h0000);

      // Sequential, jump to 0x10, branch back/forward, branch not taken.
      fetch(16'h0123, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("seq_addr", imem_addr, 16'h0001);
      fetch(16'h0010, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      fetch(16'h007E, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("br_taken_addr", imem_addr, 16'h000F);
      fetch(16'h0000, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      fetch(16'h007E, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("br_not_taken_addr", imem_addr, 16'h0011);

      // Wait states and backpressure; jump wins over a taken branch.
      fetch(16'h1FFF, 3, 2, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("jump_prio_addr", imem_addr, 16'h1FFF);
      fetch(16'h4000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      fetch(16'h0005, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("jump_pc_2005", pc, 16'h2005);
      // Upper three bits come from pc+1, so 0x2005 lands in 0x20A0.
      fetch(16'hE0A0, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("jump_addr", imem_addr, 16'h20A0);
      for (int k = 0; k < 7; k++) begin
         fetch(16'h1FFF, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk("at_ffff", pc, 16'hFFFF);

      // Halt raised mid-fetch; wrap to zero and park in IDLE.
      fetch(16'h4321, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("wrap_pc", pc, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         imem_ack   = 1'b1;
         imem_rdata = 16'hAAAA;
         step();
         chk("idle_req", 16'(imem_req), 16'h0000);
         chk("idle_valid", 16'(instr_valid), 16'h0000);
         chk("idle_pc", pc, 16'h0000);
      end
      imem_ack = 1'b0;
      fetch(16'h2222, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-fetch, with an ack arriving right after it.
      chk("pre_rst_req", 16'(imem_req), 16'h0001);
      reset = 1'b1;
      step();
      chk_reset("mid_rst");
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 16'hBEEF;
      step();
      imem_ack = 1'b0;
      chk("post_rst_valid", 16'(instr_valid), 16'h0000);
      chk("post_rst_instr", instr, 16'h0000);
      chk("post_rst_req", 16'(imem_req), 16'h0001);
      chk("post_rst_addr", imem_addr, 16'h0000);
      exp_pc = 16'h0000;
      fetch(16'h0123, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sb_empty", 16'(sb.size()), 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
